// File: rtl/pong_game_ctrl.sv
// PONG game-flow sequencer: credits, serve/play/point/game-over sequencing and scores.
// Build option: define FREE_PLAY_EN to make every start in ATTRACT begin a game without credits.
module pong_game_ctrl #(
   parameter int WIN_SCORE    = 11,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 30,
   parameter int OVER_FRAMES  = 300,
   parameter int MAX_CREDITS  = 9,
   parameter int SCORE_W      = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               vblank,
   input  logic               coin,
   input  logic               start,
   input  logic               miss_l,
   input  logic               miss_r,
   output logic [SCORE_W-1:0] score_l,
   output logic [SCORE_W-1:0] score_r,
   output logic [3:0]         credits,
   output logic               ball_en,
   output logic               serve_dir,
   output logic               attract,
   output logic               game_over,
   output logic [2:0]         state
);

   // state     | meaning
   // ATTRACT   | idle, waiting for a credited start
   // SERVE     | ball hidden, counting frames to launch
   // PLAY      | ball live, waiting for a miss
   // POINT     | ball hidden after a point
   // GAME_OVER | final score shown, then back to ATTRACT
   typedef enum logic [2:0] {
      ST_ATTRACT   = 3'd0,
      ST_SERVE     = 3'd1,
      ST_PLAY      = 3'd2,
      ST_POINT     = 3'd3,
      ST_GAME_OVER = 3'd4
   } state_t;

   localparam int MAX_F_SP = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
   localparam int MAX_F    = (MAX_F_SP > OVER_FRAMES) ? MAX_F_SP : OVER_FRAMES;
   localparam int CNT_W    = $clog2(MAX_F + 1);

   localparam logic [CNT_W-1:0]   SERVE_TC = CNT_W'(SERVE_FRAMES);
   localparam logic [CNT_W-1:0]   POINT_TC = CNT_W'(POINT_FRAMES);
   localparam logic [CNT_W-1:0]   OVER_TC  = CNT_W'(OVER_FRAMES);
   localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
   localparam logic [3:0]         MAX_CR   = 4'(MAX_CREDITS);

   state_t             state_q, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
   logic [SCORE_W-1:0] score_l_n, score_r_n;
   logic [3:0]         credits_n;
   logic               ball_en_n, serve_dir_n, start_ok;
   logic               vblank_d, coin_d, start_d, miss_l_d, miss_r_d;
   logic               tick, coin_ev, start_ev, miss_l_ev, miss_r_ev;

   assign tick      = vblank & ~vblank_d;
   assign coin_ev   = coin & ~coin_d;
   assign start_ev  = start & ~start_d;
   assign miss_l_ev = miss_l & ~miss_l_d;
   assign miss_r_ev = miss_r & ~miss_r_d;
   assign cnt_inc   = cnt + 1'b1;
   assign state     = state_q;

   always_comb begin
      state_n     = state_q;
      cnt_n       = cnt;
      score_l_n   = score_l;
      score_r_n   = score_r;
      credits_n   = credits;
      ball_en_n   = ball_en;
      serve_dir_n = serve_dir;
      start_ok    = 1'b0;
`ifdef FREE_PLAY_EN
      credits_n = 4'd0;
      start_ok  = 1'b1;
`else
      if (coin_ev && credits != MAX_CR) credits_n = credits + 4'd1;
      start_ok = (credits_n != 4'd0);
`endif
      case (state_q)
         ST_ATTRACT: begin
            if (start_ev && start_ok) begin
`ifndef FREE_PLAY_EN
               credits_n = credits_n - 4'd1;
`endif
               score_l_n   = '0;
               score_r_n   = '0;
               serve_dir_n = 1'b0;
               state_n     = ST_SERVE;
            end
         end
         ST_SERVE: begin
            if (tick) begin
               cnt_n = cnt_inc;
               if (cnt_inc == SERVE_TC) begin
                  ball_en_n = 1'b1;
                  state_n   = ST_PLAY;
               end
            end
         end
         ST_PLAY: begin
            if (miss_l_ev) begin
               if (score_r != WIN) score_r_n = score_r + 1'b1;
               serve_dir_n = 1'b0;
               ball_en_n   = 1'b0;
               state_n     = ST_POINT;
            end else if (miss_r_ev) begin
               if (score_l != WIN) score_l_n = score_l + 1'b1;
               serve_dir_n = 1'b1;
               ball_en_n   = 1'b0;
               state_n     = ST_POINT;
            end
         end
         ST_POINT: begin
            if (tick) begin
               cnt_n = cnt_inc;
               if (cnt_inc == POINT_TC)
                  state_n = (score_l == WIN || score_r == WIN) ? ST_GAME_OVER : ST_SERVE;
            end
         end
         ST_GAME_OVER: begin
            if (tick) begin
               cnt_n = cnt_inc;
               if (cnt_inc == OVER_TC) state_n = ST_ATTRACT;
            end
         end
         default: state_n = ST_ATTRACT;
      endcase
      // frame count restarts from zero in every new state
      if (state_n != state_q) cnt_n = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_ATTRACT;
         cnt       <= '0;
         score_l   <= '0;
         score_r   <= '0;
         credits   <= 4'd0;
         ball_en   <= 1'b0;
         serve_dir <= 1'b0;
         attract   <= 1'b1;
         game_over <= 1'b0;
         vblank_d  <= 1'b0;
         coin_d    <= 1'b0;
         start_d   <= 1'b0;
         miss_l_d  <= 1'b0;
         miss_r_d  <= 1'b0;
      end else begin
         state_q   <= state_n;
         cnt       <= cnt_n;
         score_l   <= score_l_n;
         score_r   <= score_r_n;
         credits   <= credits_n;
         ball_en   <= ball_en_n;
         serve_dir <= serve_dir_n;
         attract   <= (state_n == ST_ATTRACT);
         game_over <= (state_n == ST_GAME_OVER);
         vblank_d  <= vblank;
         coin_d    <= coin;
         start_d   <= start;
         miss_l_d  <= miss_l;
         miss_r_d  <= miss_r;
      end
   end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: reference model feeds an expected-value queue, popped after each clock.
// Honours FREE_PLAY_EN the same way as the design.
module tb_pong_game_ctrl;

`ifdef FREE_PLAY_EN
   localparam bit FREE = 1'b1;
`else
   localparam bit FREE = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, vblank, coin, start, miss_l, miss_r;
   logic [3:0] score_l, score_r, credits;
   logic       ball_en, serve_dir, attract, game_over;
   logic [2:0] state;

   pong_game_ctrl dut (
      .clk(clk), .reset(reset), .vblank(vblank), .coin(coin), .start(start),
      .miss_l(miss_l), .miss_r(miss_r), .score_l(score_l), .score_r(score_r),
      .credits(credits), .ball_en(ball_en), .serve_dir(serve_dir),
      .attract(attract), .game_over(game_over), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      int st; int sl; int sr; int cr; int be; int sd; int at; int go;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;

   int m_st, m_sl, m_sr, m_cr, m_be, m_sd, m_cnt;
   logic p_vb, p_cn, p_st, p_ml, p_mr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_st = 0; m_sl = 0; m_sr = 0; m_cr = 0; m_be = 0; m_sd = 0; m_cnt = 0;
      p_vb = 0; p_cn = 0; p_st = 0; p_ml = 0; p_mr = 0;
   endtask

   task automatic model_next(input logic vb, cn, st, ml, mr);
      logic tk, ce, se, le, re;
      tk = vb & ~p_vb; ce = cn & ~p_cn; se = st & ~p_st; le = ml & ~p_ml; re = mr & ~p_mr;
      p_vb = vb; p_cn = cn; p_st = st; p_ml = ml; p_mr = mr;
      if (ce && !FREE && m_cr < 9) m_cr++;
      case (m_st)
         0: if (se && (FREE || m_cr > 0)) begin
               if (!FREE) m_cr--;
               m_sl = 0; m_sr = 0; m_sd = 0; m_cnt = 0; m_st = 1;
            end
         1: if (tk) begin
               m_cnt++;
               if (m_cnt == 60) begin m_st = 2; m_be = 1; m_cnt = 0; end
            end
         2: if (le) begin
               if (m_sr < 11) m_sr++;
               m_sd = 0; m_be = 0; m_cnt = 0; m_st = 3;
            end else if (re) begin
               if (m_sl < 11) m_sl++;
               m_sd = 1; m_be = 0; m_cnt = 0; m_st = 3;
            end
         3: if (tk) begin
               m_cnt++;
               if (m_cnt == 30) begin m_st = (m_sl == 11 || m_sr == 11) ? 4 : 1; m_cnt = 0; end
            end
         default: if (tk) begin
               m_cnt++;
               if (m_cnt == 300) begin m_st = 0; m_cnt = 0; end
            end
      endcase
   endtask

   task automatic step(input logic vb, cn, st, ml, mr);
      exp_t e;
      vblank = vb; coin = cn; start = st; miss_l = ml; miss_r = mr;
      model_next(vb, cn, st, ml, mr);
      e = '{st: m_st, sl: m_sl, sr: m_sr, cr: m_cr, be: m_be, sd: m_sd,
            at: (m_st == 0), go: (m_st == 4)};
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      chk("state", 32'(state), e.st);
      chk("score_l", 32'(score_l), e.sl);
      chk("score_r", 32'(score_r), e.sr);
      chk("credits", 32'(credits), e.cr);
      chk("ball_en", 32'(ball_en), e.be);
      chk("serve_dir", 32'(serve_dir), e.sd);
      chk("attract", 32'(attract), e.at);
      chk("game_over", 32'(game_over), e.go);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         step(1, 0, 0, 0, 0);
         step(0, 0, 0, 0, 0);
      end
   endtask

   task automatic point(input logic ml, input logic mr);
      step(0, 0, 0, ml, mr);
      step(0, 0, 0, 0, 0);
      frames(30);
      if (m_st == 1) frames(60);
   endtask

   task automatic reset_check(input string tag);
      vblank = 0; coin = 0; start = 0; miss_l = 0; miss_r = 0;
      reset = 1'b1;
      #1;
      model_clear();
      chk({tag, "_state"}, 32'(state), 0);
      chk({tag, "_score_l"}, 32'(score_l), 0);
      chk({tag, "_score_r"}, 32'(score_r), 0);
      chk({tag, "_credits"}, 32'(credits), 0);
      chk({tag, "_ball_en"}, 32'(ball_en), 0);
      chk({tag, "_serve_dir"}, 32'(serve_dir), 0);
      chk({tag, "_attract"}, 32'(attract), 1);
      chk({tag, "_game_over"}, 32'(game_over), 0);
      #2 reset = 1'b0;
   endtask

   initial begin
      vblank = 0; coin = 0; start = 0; miss_l = 0; miss_r = 0;
      reset = 1'b1;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      reset_check("por");
      step(0, 0, 0, 0, 0);

      // three coins then start
      for (int i = 1; i <= 3; i++) begin
         step(0, 1, 0, 0, 0);
         chk("t2_credit_inc", 32'(credits), FREE ? 0 : i);
         step(0, 0, 0, 0, 0);
      end
      step(0, 0, 1, 0, 0);
      chk("t2_start_state", 32'(state), 1);
      chk("t2_start_credits", 32'(credits), FREE ? 0 : 2);
      step(0, 0, 0, 0, 0);
      frames(59);
      chk("t2_serve_59", 32'(state), 1);
      frames(1);
      chk("t2_play_state", 32'(state), 2);
      chk("t2_play_ball", 32'(ball_en), 1);

      // miss_l -> point to the right
      step(0, 0, 0, 1, 0);
      chk("t3_score_r", 32'(score_r), 1);
      chk("t3_ball_off", 32'(ball_en), 0);
      chk("t3_point", 32'(state), 3);
      step(0, 0, 0, 0, 0);
      frames(29);
      chk("t3_point_29", 32'(state), 3);
      frames(1);
      chk("t3_back_serve", 32'(state), 1);
      frames(60);

      // simultaneous misses: left miss wins
      step(0, 0, 0, 1, 1);
      chk("t4_score_r", 32'(score_r), 2);
      chk("t4_score_l", 32'(score_l), 0);
      chk("t4_dir", 32'(serve_dir), 0);
      step(0, 0, 0, 0, 0);
      frames(30);
      frames(60);

      for (int i = 0; i < 3; i++) point(1, 0);
      for (int i = 0; i < 3; i++) point(0, 1);
      chk("t1_pre_l", 32'(score_l), 3);
      chk("t1_pre_r", 32'(score_r), 5);
      chk("t1_pre_state", 32'(state), 2);
      reset_check("t1_rst");
      step(0, 0, 0, 0, 0);

      // start with no credits, then saturation
      step(0, 0, 1, 0, 0);
      chk("t6_nocredit_start", 32'(state), FREE ? 1 : 0);
      step(0, 0, 0, 0, 0);
      if (FREE) begin
         chk("t6_free_credits", 32'(credits), 0);
         reset_check("t6_rst");
         step(0, 0, 0, 0, 0);
      end
      for (int i = 0; i < 12; i++) begin
         step(0, 1, 0, 0, 0);
         step(0, 0, 0, 0, 0);
      end
      chk("t6_saturate", 32'(credits), FREE ? 0 : 9);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("t6_start", 32'(state), 1);
      frames(60);

      // left player runs to the winning score
      for (int i = 0; i < 10; i++) point(0, 1);
      chk("t5_score_10", 32'(score_l), 10);
      step(0, 0, 0, 0, 1);
      chk("t5_score_11", 32'(score_l), 11);
      chk("t5_point", 32'(state), 3);
      chk("t5_dir", 32'(serve_dir), 1);
      step(0, 0, 0, 0, 0);
      frames(30);
      chk("t5_game_over", 32'(game_over), 1);
      step(0, 1, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("t5_start_ignored", 32'(state), 4);
      frames(299);
      chk("t5_over_299", 32'(state), 4);
      frames(1);
      chk("t5_attract", 32'(attract), 1);
      chk("t5_held_l", 32'(score_l), 11);
      chk("t5_held_r", 32'(score_r), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
